// File: rtl/ntp_time_select.sv
// rtl/ntp_time_select.sv - qualifies two NTP time sources and drives one selected time stream
// Optional NTP_SEL_REVERTIVE_EN: auto mode returns from B to A once A has re-proven itself.
module ntp_time_select #(
   parameter int UPD_TIMEOUT = 1000,
   parameter int QUAL_COUNT  = 8
) (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic [63:0] ntp_time_a,
   input  logic        ntp_time_upd_a,
   input  logic        sync_ok_a,
   input  logic [63:0] ntp_time_b,
   input  logic        ntp_time_upd_b,
   input  logic        sync_ok_b,
   input  logic [1:0]  force_sel,
   output logic [63:0] ntp_time,
   output logic        ntp_time_upd,
   output logic        sel_b,
   output logic        holdover,
   output logic        qual_a,
   output logic        qual_b,
   output logic [15:0] switch_cnt
);
   localparam int SCW = $clog2(UPD_TIMEOUT + 1);
   localparam logic [SCW-1:0] STALE_MAX = SCW'(UPD_TIMEOUT);
   localparam logic [7:0]     QUAL_MAX  = 8'(QUAL_COUNT);

   typedef enum logic [1:0] {S_INIT, S_A, S_B, S_HOLD} state_t;

   // Index 0 is source A, index 1 is source B throughout.
   logic [1:0][63:0]    w_time;
   logic [1:0]          w_upd;
   logic [1:0]          w_sync;

   logic [1:0][SCW-1:0] r_stale_cnt;
   logic [1:0][7:0]     r_good_cnt;
   logic [1:0][7:0]     w_good_nxt;
   logic [1:0][63:0]    r_last_time;
   logic [1:0]          r_qual;
   logic [1:0]          w_stale;
   logic [1:0]          w_good;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [63:0]         r_ntp_time;
   logic                r_ntp_time_upd;
   logic [15:0]         r_switch_cnt;
   logic                w_force_a;
   logic                w_force_b;
   logic                w_out_fire;
   logic                w_switch;

   assign w_time = {ntp_time_b, ntp_time_a};
   assign w_upd  = {ntp_time_upd_b, ntp_time_upd_a};
   assign w_sync = {sync_ok_b, sync_ok_a};

   assign w_force_a = (force_sel == 2'b01);
   assign w_force_b = (force_sel == 2'b10);

   always_comb begin
      w_stale    = '0;
      w_good     = '0;
      w_good_nxt = r_good_cnt;
      for (int i = 0; i < 2; i++) begin
         w_stale[i] = (r_stale_cnt[i] == STALE_MAX);
         w_good[i]  = w_sync[i] && !w_stale[i] && (w_time[i] > r_last_time[i]);
         if (w_upd[i]) begin
            if (!w_good[i])
               w_good_nxt[i] = '0;
            else if (r_good_cnt[i] != QUAL_MAX)
               w_good_nxt[i] = r_good_cnt[i] + 8'd1;
         end else if (!w_sync[i] || w_stale[i]) begin
            w_good_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_stale_cnt <= '0;
         r_good_cnt  <= '0;
         r_last_time <= '0;
         r_qual      <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_upd[i]) begin
               r_stale_cnt[i] <= '0;
               r_last_time[i] <= w_time[i];
            end else if (!w_stale[i]) begin
               r_stale_cnt[i] <= r_stale_cnt[i] + SCW'(1);
            end
            r_good_cnt[i] <= w_good_nxt[i];
            r_qual[i]     <= (w_good_nxt[i] == QUAL_MAX);
         end
      end
   end

`ifdef NTP_SEL_REVERTIVE_EN
   // Counts A strobes seen while parked on B in auto mode with A already qualified.
   logic [7:0] r_rev_cnt;
   logic       w_rev_arm;
   logic       w_rev_done;

   assign w_rev_arm  = !w_force_a && !w_force_b && (r_state == S_B) && r_qual[0];
   assign w_rev_done = w_rev_arm && (r_rev_cnt == QUAL_MAX);

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)
         r_rev_cnt <= '0;
      else if (!w_rev_arm)
         r_rev_cnt <= '0;
      else if (ntp_time_upd_a && (r_rev_cnt != QUAL_MAX))
         r_rev_cnt <= r_rev_cnt + 8'd1;
   end
`endif

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)
         r_state <= S_INIT;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_force_a) begin
         w_state_nxt = S_A;
      end else if (w_force_b) begin
         w_state_nxt = S_B;
      end else begin
         case (r_state)
            S_INIT, S_HOLD: begin
               if (r_qual[0])
                  w_state_nxt = S_A;
               else if (r_qual[1])
                  w_state_nxt = S_B;
            end
            S_A: begin
               if (!r_qual[0])
                  w_state_nxt = r_qual[1] ? S_B : S_HOLD;
            end
            S_B: begin
               if (!r_qual[1])
                  w_state_nxt = r_qual[0] ? S_A : S_HOLD;
`ifdef NTP_SEL_REVERTIVE_EN
               else if (w_rev_done)
                  w_state_nxt = S_A;
`endif
            end
            default: w_state_nxt = S_INIT;
         endcase
      end
   end

   // Mux follows the current state, so a strobe in a transition cycle uses the old source.
   assign w_out_fire = ((r_state == S_A) && r_qual[0] && ntp_time_upd_a) ||
                       ((r_state == S_B) && r_qual[1] && ntp_time_upd_b);

   assign w_switch = ((r_state == S_A) && (w_state_nxt == S_B)) ||
                     ((r_state == S_B) && (w_state_nxt == S_A));

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_ntp_time     <= '0;
         r_ntp_time_upd <= 1'b0;
         r_switch_cnt   <= '0;
      end else begin
         r_ntp_time_upd <= w_out_fire;
         if (w_out_fire)
            r_ntp_time <= (r_state == S_B) ? ntp_time_b : ntp_time_a;
         if (w_switch && (r_switch_cnt != 16'hFFFF))
            r_switch_cnt <= r_switch_cnt + 16'd1;
      end
   end

   assign ntp_time     = r_ntp_time;
   assign ntp_time_upd = r_ntp_time_upd;
   assign sel_b        = (r_state == S_B);
   assign holdover     = (r_state == S_INIT) || (r_state == S_HOLD) ||
                         (w_force_a && !r_qual[0]) || (w_force_b && !r_qual[1]);
   assign qual_a       = r_qual[0];
   assign qual_b       = r_qual[1];
   assign switch_cnt   = r_switch_cnt;

endmodule

// File: tb/tb_ntp_time_select.sv
// tb/tb_ntp_time_select.sv - self-checking bench for ntp_time_select
// Honours NTP_SEL_REVERTIVE_EN when the design is built with it.
module tb_ntp_time_select;
   localparam int T = 1000;
   localparam int Q = 8;
   localparam logic [63:0] ONE_SEC = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] ntp_time_a, ntp_time_b;
   logic        upd_a, upd_b, sync_a, sync_b;
   logic [1:0]  force_sel;
   logic [63:0] ntp_time;
   logic        ntp_time_upd, sel_b, holdover, qual_a, qual_b;
   logic [15:0] switch_cnt;

   always #5 clk = ~clk;

   ntp_time_select #(.UPD_TIMEOUT(T), .QUAL_COUNT(Q)) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .ntp_time_a(ntp_time_a), .ntp_time_upd_a(upd_a), .sync_ok_a(sync_a),
      .ntp_time_b(ntp_time_b), .ntp_time_upd_b(upd_b), .sync_ok_b(sync_b),
      .force_sel(force_sel), .ntp_time(ntp_time), .ntp_time_upd(ntp_time_upd),
      .sel_b(sel_b), .holdover(holdover), .qual_a(qual_a), .qual_b(qual_b),
      .switch_cnt(switch_cnt));

   int checks = 0;
   int failures = 0;

   // Reference model: selected source as -1 (none) / 0 (A) / 1 (B); staleness from timestamps.
   longint unsigned m_edge;
   longint unsigned m_last_edge [2];
   logic [63:0]     m_last_t [2];
   int              m_streak [2];
   bit              m_q [2];
   int              m_src;
   int              m_rev;
   logic [63:0]     m_time;
   bit              m_upd;
   int              m_sw;

   task automatic model_reset();
      m_edge = 0; m_src = -1; m_rev = 0; m_time = '0; m_upd = 0; m_sw = 0;
      for (int x = 0; x < 2; x++) begin
         m_last_edge[x] = 0; m_last_t[x] = '0; m_streak[x] = 0; m_q[x] = 0;
      end
   endtask

   task automatic model_step();
      logic [63:0] tv [2];
      bit up [2];
      bit sy [2];
      bit q_old [2];
      bit stale;
      bit auto_m;
      int nsrc;
      tv[0] = ntp_time_a; tv[1] = ntp_time_b;
      up[0] = upd_a;      up[1] = upd_b;
      sy[0] = sync_a;     sy[1] = sync_b;
      q_old[0] = m_q[0];  q_old[1] = m_q[1];
      auto_m = !(force_sel == 2'b01 || force_sel == 2'b10);
      m_edge++;
      for (int x = 0; x < 2; x++) begin
         stale = (m_edge - 1 - m_last_edge[x]) >= T;
         if (up[x]) begin
            if (sy[x] && !stale && tv[x] > m_last_t[x])
               m_streak[x] = (m_streak[x] < 1000) ? m_streak[x] + 1 : m_streak[x];
            else
               m_streak[x] = 0;
            m_last_t[x] = tv[x];
            m_last_edge[x] = m_edge;
         end else if (!sy[x] || stale) begin
            m_streak[x] = 0;
         end
         m_q[x] = (m_streak[x] >= Q);
      end
      m_upd = 0;
      if (m_src >= 0 && up[m_src] && q_old[m_src]) begin
         m_time = tv[m_src];
         m_upd = 1;
      end
      if (force_sel == 2'b01) nsrc = 0;
      else if (force_sel == 2'b10) nsrc = 1;
      else if (m_src < 0) nsrc = q_old[0] ? 0 : (q_old[1] ? 1 : -1);
      else if (!q_old[m_src]) nsrc = q_old[1 - m_src] ? 1 - m_src : -1;
      else nsrc = m_src;
`ifdef NTP_SEL_REVERTIVE_EN
      if (auto_m && m_src == 1 && q_old[1] && q_old[0] && m_rev >= Q) nsrc = 0;
`endif
      if (auto_m && m_src == 1 && q_old[0]) m_rev = m_rev + (up[0] ? 1 : 0);
      else m_rev = 0;
      if (((m_src == 0 && nsrc == 1) || (m_src == 1 && nsrc == 0)) && m_sw < 65535)
         m_sw++;
      m_src = nsrc;
   endtask

   function automatic logic [127:0] model_outs();
      bit hold;
      hold = (m_src < 0) || (force_sel == 2'b01 && !m_q[0]) || (force_sel == 2'b10 && !m_q[1]);
      return {43'd0, m_time, m_upd, (m_src == 1), hold, m_q[0], m_q[1], m_sw[15:0]};
   endfunction

   function automatic logic [127:0] dut_outs();
      return {43'd0, ntp_time, ntp_time_upd, sel_b, holdover, qual_a, qual_b, switch_cnt};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      chk("cycle", dut_outs(), model_outs());
   endtask

   typedef struct {
      int       ncyc;
      int       per_a;
      int       per_b;
      bit       sy_a;
      bit       sy_b;
      bit       back_a;
      logic [1:0] frc;
      bit       e_sel_b;
      bit       e_hold;
      bit       e_qa;
      bit       e_qb;
   } vec_t;

   vec_t vecs [9];
   int   gc = 0;
   logic [63:0] ta = '0;
   logic [63:0] tb = '0;

   task automatic run_phase(input vec_t v, input string nm);
      for (int c = 0; c < v.ncyc; c++) begin
         gc++;
         upd_a = (v.per_a != 0) && (gc % v.per_a == 1);
         upd_b = (v.per_b != 0) && (gc % v.per_b == v.per_b / 2);
         sync_a = v.sy_a; sync_b = v.sy_b; force_sel = v.frc;
         if (upd_a) begin ta = v.back_a ? ta - 64'd1 : ta + ONE_SEC; ntp_time_a = ta; end
         if (upd_b) begin tb = tb + ONE_SEC; ntp_time_b = tb; end
         tick();
      end
      chk({nm, ".sel_b"},    128'(sel_b),    128'(v.e_sel_b));
      chk({nm, ".holdover"}, 128'(holdover), 128'(v.e_hold));
      chk({nm, ".qual_a"},   128'(qual_a),   128'(v.e_qa));
      chk({nm, ".qual_b"},   128'(qual_b),   128'(v.e_qb));
   endtask

   localparam logic [127:0] RESET_OUTS = {43'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

   initial begin
      vec_t w;
      bit   rev_sel;
      rst_n = 1'b0; ntp_time_a = '0; ntp_time_b = '0; upd_a = 0; upd_b = 0;
      sync_a = 0; sync_b = 0; force_sel = 2'b00;
      model_reset();
`ifdef NTP_SEL_REVERTIVE_EN
      rev_sel = 1'b0;
`else
      rev_sel = 1'b1;
`endif
      //          ncyc  pa   pb  sa sb bk frc   selb hold qa qb
      vecs[0] = '{ 900, 100, 100, 1, 1, 0, 2'b00, 0, 0, 1, 1};
      vecs[1] = '{ 300, 100, 100, 0, 1, 0, 2'b00, 1, 0, 0, 1};
      vecs[2] = '{1100,   0,   0, 1, 1, 0, 2'b00, 0, 1, 0, 0};
      vecs[3] = '{1100, 100, 100, 1, 1, 0, 2'b00, 0, 0, 1, 1};
      vecs[4] = '{ 300, 100, 100, 1, 1, 1, 2'b00, 1, 0, 0, 1};
      vecs[5] = '{1800, 100, 100, 1, 1, 0, 2'b00, rev_sel, 0, 1, 1};
      vecs[6] = '{ 300, 100, 100, 1, 1, 0, 2'b01, 0, 0, 1, 1};
      vecs[7] = '{ 300, 100, 100, 1, 0, 0, 2'b10, 1, 1, 1, 0};
      vecs[8] = '{ 200, 100, 100, 1, 0, 0, 2'b00, 0, 0, 1, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", dut_outs(), RESET_OUTS);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_phase(vecs[i], $sformatf("vec%0d", i));

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         upd_a = ($urandom_range(0, 39) == 0);
         upd_b = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 299) == 0) sync_a = ~sync_a;
         if ($urandom_range(0, 299) == 0) sync_b = ~sync_b;
         if ($urandom_range(0, 599) == 0) force_sel = 2'($urandom_range(0, 3));
         if (upd_a) begin
            ta = ($urandom_range(0, 9) == 0) ? ta - 64'd1 : ta + ONE_SEC;
            ntp_time_a = ta;
         end
         if (upd_b) begin tb = tb + ONE_SEC; ntp_time_b = tb; end
         tick();
      end

      // Asynchronous reset in the middle of a cycle.
      #2;
      rst_n = 1'b0; upd_a = 0; upd_b = 0;
      #1;
      chk("async_reset", dut_outs(), RESET_OUTS);
      model_reset();
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      gc = 0;

      w = vecs[0];
      run_phase(w, "requal");
      chk("requal.switch_cnt", 128'(switch_cnt), 128'd0);

      // Forced switch with both strobes in the transition cycle: A's time wins that cycle.
      upd_a = 1; upd_b = 1; force_sel = 2'b10;
      ta = ta + ONE_SEC; ntp_time_a = ta;
      tb = tb + ONE_SEC; ntp_time_b = tb;
      tick();
      chk("sw.time_a",     128'(ntp_time),     128'(ta));
      chk("sw.upd",        128'(ntp_time_upd), 128'd1);
      chk("sw.sel_b",      128'(sel_b),        128'd1);
      chk("sw.switch_cnt", 128'(switch_cnt),   128'd1);
      upd_a = 0; upd_b = 0;
      tick();
      upd_a = 1; upd_b = 1;
      ta = ta + ONE_SEC; ntp_time_a = ta;
      tb = tb + ONE_SEC; ntp_time_b = tb;
      tick();
      chk("sw.time_b", 128'(ntp_time), 128'(tb));

      w.frc = 2'b00; w.e_sel_b = rev_sel;
      run_phase(w, "revert");
`ifdef NTP_SEL_REVERTIVE_EN
      chk("revert.switch_cnt", 128'(switch_cnt), 128'd2);
`else
      chk("revert.switch_cnt", 128'(switch_cnt), 128'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
